memd_resp: RTL and testbench
============================

MEMD_RESP -- requirements
Module: memd_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 2, cycles from request acceptance until the response is eligible (legal range 1..7).
REQ-002 SHALL have parameter QDEPTH_LOG, default 2, log2 of in-flight request queue depth (QDEPTH = 4).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  squash; drops all in-flight requests.
REQ-006 SHALL have port req_valid  input  1  load request present.
REQ-007 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-008 SHALL have port req_addr  input  `MEMD_SIZE_LOG  word address.
REQ-009 SHALL have port req_tag  input  `ROB_SIZE_LOG  requester ROB index, returned unchanged.
REQ-010 SHALL have port resp_valid  output  1  response present.
REQ-011 SHALL have port resp_ready  input  1  requester consumes the response.
REQ-012 SHALL have port resp_tag  output  `ROB_SIZE_LOG  tag of the presented response.
REQ-013 SHALL have port resp_data  output  `REG_LEN  loaded word.

Function
REQ-014 SHALL hold storage memd of `MEMD_SIZE words of `REG_LEN bits, read-only after reset.
REQ-015 SHALL accept a request on a cycle with req_valid && req_ready && !flush.
REQ-016 SHALL drive req_ready = !full, depending only on registered state, never on resp_ready.
REQ-017 SHALL sample memd[req_addr] and req_tag into the entry at the tail pointer on acceptance, then advance the tail.
REQ-018 SHALL give each entry the states IDLE -> WAIT (on accept, countdown = LATENCY-1) -> DONE (when countdown reaches 0) -> IDLE (on pop); LATENCY=1 enters DONE directly.
REQ-019 SHALL decrement the countdown of every WAIT entry each cycle, independent of the head.
REQ-020 SHALL assert resp_valid only when the head entry is DONE, with resp_tag and resp_data taken from the head entry; responses are in order.
REQ-021 SHALL pop the head (IDLE, head+1) on resp_valid && resp_ready; resp_valid, tag, and data SHALL hold stable while resp_ready is low.
REQ-022 SHALL give a request accepted at cycle t its earliest resp_valid at cycle t+LATENCY.
REQ-023 SHALL wrap head and tail pointers modulo QDEPTH; full = tail entry not IDLE, empty = head entry IDLE.
REQ-024 SHALL allow push and pop in the same cycle when not full; occupancy is then unchanged.
REQ-025 SHALL make flush dominate: next cycle all entries are IDLE, head = tail = 0, resp_valid = 0; a same-cycle request and handshake are discarded.

Reset
REQ-026 SHALL, on rst, set all entries to IDLE, head = tail = 0, giving resp_valid = 0 and req_ready = 1 next cycle.
REQ-027 SHALL give rst priority over flush and over any handshake, including mid-operation.
REQ-028 SHALL load memd with all zeros on rst unless REQ-029 applies.

Configuration
REQ-029 SHALL, with macro MEMD_RESP_INIT_CUSTOM_EN defined, load memd[0]=0, memd[1]=1, memd[2]=0, memd[3]=0 on rst and all other words 0; without the macro, all words SHALL be 0.

Verification
REQ-030 SHALL cover basic latency: CUSTOM_EN, LATENCY=2, request addr=1 tag=3 at cycle 5 with resp_ready=1 -> resp_valid at cycle 7 with tag=3, data=1, then queue empty.
REQ-031 SHALL cover backpressure/full: 4 requests (tags 0..3) on back-to-back cycles, resp_ready=0 -> req_ready=0 after the 4th; a 5th request is not accepted; resp_tag holds 0 and does not change.
REQ-032 SHALL cover in-order/wrap: 6 requests with tags 5,6,7,0,1,2 and resp_ready=1 continuously -> responses are returned in the same tag order, and the pointers wrap with no loss.
REQ-033 SHALL cover flush mid-flight: 3 requests outstanding and flush=1 with a 4th request present -> next cycle resp_valid=0, req_ready=1, no response for any of the 4 tags.
REQ-034 SHALL cover simultaneous push/pop: 2 entries in the queue, head DONE, push and pop in the same cycle -> occupancy stays 2 and the next response carries the second tag.
REQ-035 SHALL cover reset mid-operation: rst=1 while resp_valid=1 and resp_ready=0 -> next cycle resp_valid=0, req_ready=1; a new request addr=1 then returns data 1 with the macro defined and 0 without it.

Source files
------------

// File: rtl/memd_resp.sv
// In-order load responder: read-only word memory behind a small in-flight queue with fixed latency.
// Define MEMD_RESP_INIT_CUSTOM_EN to load memd[1]=1 on reset; otherwise memd resets to all zeros.

`ifndef MEMD_SIZE_LOG
`define MEMD_SIZE_LOG 4
`endif
`ifndef MEMD_SIZE
`define MEMD_SIZE (1 << `MEMD_SIZE_LOG)
`endif
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 3
`endif
`ifndef REG_LEN
`define REG_LEN 32
`endif

module memd_resp #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned QDEPTH_LOG = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [`MEMD_SIZE_LOG-1:0] req_addr,
  input  logic [`ROB_SIZE_LOG-1:0]  req_tag,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [`ROB_SIZE_LOG-1:0]  resp_tag,
  output logic [`REG_LEN-1:0]       resp_data
);

  localparam int unsigned QDEPTH = 1 << QDEPTH_LOG;

  typedef logic [QDEPTH_LOG-1:0] ptr_t;
  typedef enum logic [1:0] {StIdle, StWait, StDone} ent_state_e;

  logic [`REG_LEN-1:0]      memd [`MEMD_SIZE];

  ent_state_e               st_q   [QDEPTH];
  ent_state_e               st_d   [QDEPTH];
  logic [2:0]               cnt_q  [QDEPTH];
  logic [2:0]               cnt_d  [QDEPTH];
  logic [`ROB_SIZE_LOG-1:0] tag_q  [QDEPTH];
  logic [`REG_LEN-1:0]      data_q [QDEPTH];
  ptr_t                     head_q, head_d;
  ptr_t                     tail_q, tail_d;

  logic full, push, pop;

  assign full       = (st_q[tail_q] != StIdle);
  assign req_ready  = !full;
  assign resp_valid = (st_q[head_q] == StDone);
  assign resp_tag   = tag_q[head_q];
  assign resp_data  = data_q[head_q];
  assign push       = req_valid && req_ready && !flush;
  assign pop        = resp_valid && resp_ready && !flush;

  // Memory contents are fixed at reset and never written afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < `MEMD_SIZE; i++) begin
        memd[i] <= '0;
      end
`ifdef MEMD_RESP_INIT_CUSTOM_EN
      memd[1] <= `REG_LEN'(1);
`else
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        st_q[i]  <= StIdle;
        cnt_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail_q]  <= req_tag;
      data_q[tail_q] <= memd[req_addr];
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;

    // Every waiting entry counts down on its own, regardless of queue position.
    for (int i = 0; i < QDEPTH; i++) begin
      if (st_q[i] == StWait) begin
        if (cnt_q[i] <= 3'd1) begin
          st_d[i]  = StDone;
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] - 3'd1;
        end
      end
    end

    if (pop) begin
      st_d[head_q] = StIdle;
      head_d       = head_q + ptr_t'(1);
    end

    if (push) begin
      st_d[tail_q]  = (LATENCY == 1) ? StDone : StWait;
      cnt_d[tail_q] = 3'(LATENCY - 1);
      tail_d        = tail_q + ptr_t'(1);
    end

    if (flush) begin
      for (int i = 0; i < QDEPTH; i++) begin
        st_d[i]  = StIdle;
        cnt_d[i] = '0;
      end
      head_d = '0;
      tail_d = '0;
    end
  end

endmodule

// File: tb/tb_memd_resp.sv
// Directed bench for memd_resp: latency, backpressure, ordering/wrap, flush, push+pop, reset.

`ifndef MEMD_SIZE_LOG
`define MEMD_SIZE_LOG 4
`endif
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 3
`endif
`ifndef REG_LEN
`define REG_LEN 32
`endif

module tb_memd_resp;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic                      req_valid;
  logic                      req_ready;
  logic [`MEMD_SIZE_LOG-1:0] req_addr;
  logic [`ROB_SIZE_LOG-1:0]  req_tag;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [`ROB_SIZE_LOG-1:0]  resp_tag;
  logic [`REG_LEN-1:0]       resp_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [`ROB_SIZE_LOG-1:0] exp_tag_q  [$];
  logic [`REG_LEN-1:0]      exp_data_q [$];

  memd_resp #(
    .LATENCY   (2),
    .QDEPTH_LOG(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_tag   (req_tag),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_tag  (resp_tag),
    .resp_data (resp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [`REG_LEN-1:0] exp_data(input int addr);
`ifdef MEMD_RESP_INIT_CUSTOM_EN
    return (addr == 1) ? `REG_LEN'(1) : '0;
`else
    return (addr < 0) ? `REG_LEN'(1) : '0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input int addr, input int tag);
    req_valid = v;
    req_addr  = `MEMD_SIZE_LOG'(addr);
    req_tag   = `ROB_SIZE_LOG'(tag);
  endtask

  // Consume responses for a bounded number of cycles and match them against the expected queues.
  task automatic collect(input string name, input int budget);
    int extra = 0;
    resp_ready = 1'b1;
    repeat (budget) begin
      if (resp_valid) begin
        if (exp_tag_q.size() == 0) begin
          extra++;
        end else begin
          check({name, "_tag"}, 32'(resp_tag), 32'(exp_tag_q.pop_front()));
          check({name, "_data"}, 32'(resp_data), 32'(exp_data_q.pop_front()));
        end
      end
      step();
    end
    check({name, "_missing"}, 32'(exp_tag_q.size()), 32'd0);
    check({name, "_extra"}, 32'(extra), 32'd0);
    exp_tag_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    int issued;
    int got;
    int tags_w[6];
    int extra;

    rst = 1'b1; flush = 1'b0; resp_ready = 1'b0;
    drive_req(1'b0, 0, 0);
    step();
    step();
    rst = 1'b0;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // Basic latency: accepted at t, visible at t+2, then empty.
    resp_ready = 1'b1;
    drive_req(1'b1, 1, 3);
    step();
    drive_req(1'b0, 0, 0);
    check("lat_t1_valid", 32'(resp_valid), 32'd0);
    step();
    check("lat_t2_valid", 32'(resp_valid), 32'd1);
    check("lat_t2_tag", 32'(resp_tag), 32'd3);
    check("lat_t2_data", 32'(resp_data), 32'(exp_data(1)));
    step();
    check("lat_empty", 32'(resp_valid), 32'd0);
    check("lat_ready", 32'(req_ready), 32'd1);

    // Backpressure until full.
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_ready_pre", 32'(req_ready), 32'd1);
      drive_req(1'b1, i, i);
      exp_tag_q.push_back(`ROB_SIZE_LOG'(i));
      exp_data_q.push_back(exp_data(i));
      step();
    end
    drive_req(1'b1, 1, 4);
    check("bp_full", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_valid", 32'(resp_valid), 32'd1);
      check("bp_hold_tag", 32'(resp_tag), 32'd0);
      check("bp_still_full", 32'(req_ready), 32'd0);
    end
    drive_req(1'b0, 0, 0);
    collect("bp_drain", 12);

    // In-order with pointer wrap; issue and consume concurrently.
    tags_w = '{5, 6, 7, 0, 1, 2};
    issued = 0;
    got = 0;
    extra = 0;
    resp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (resp_valid) begin
        if (got < 6) begin
          check("wrap_tag", 32'(resp_tag), 32'(tags_w[got]));
          check("wrap_data", 32'(resp_data), 32'(exp_data(got % 4)));
          got++;
        end else begin
          extra++;
        end
      end
      if (issued < 6 && req_ready) begin
        drive_req(1'b1, issued % 4, tags_w[issued]);
        issued++;
      end else begin
        drive_req(1'b0, 0, 0);
      end
      step();
    end
    check("wrap_count", 32'(got), 32'd6);
    check("wrap_extra", 32'(extra), 32'd0);

    // Flush with a fourth request on the same cycle.
    resp_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive_req(1'b1, i, i);
      step();
    end
    drive_req(1'b1, 1, 4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive_req(1'b0, 0, 0);
    check("flush_valid", 32'(resp_valid), 32'd0);
    check("flush_ready", 32'(req_ready), 32'd1);
    collect("flush_none", 10);

    // Push and pop in the same cycle with two entries queued.
    resp_ready = 1'b0;
    drive_req(1'b1, 0, 6);
    step();
    drive_req(1'b1, 1, 7);
    step();
    check("pp_head_valid", 32'(resp_valid), 32'd1);
    check("pp_head_tag", 32'(resp_tag), 32'd6);
    drive_req(1'b1, 2, 5);
    resp_ready = 1'b1;
    step();
    drive_req(1'b0, 0, 0);
    resp_ready = 1'b0;
    check("pp_next_valid", 32'(resp_valid), 32'd1);
    check("pp_next_tag", 32'(resp_tag), 32'd7);
    exp_tag_q.push_back(`ROB_SIZE_LOG'(7));
    exp_data_q.push_back(exp_data(1));
    exp_tag_q.push_back(`ROB_SIZE_LOG'(5));
    exp_data_q.push_back(exp_data(2));
    collect("pp_drain", 10);

    // Reset while a response is stalled.
    resp_ready = 1'b0;
    drive_req(1'b1, 0, 2);
    step();
    drive_req(1'b0, 0, 0);
    step();
    check("rmid_pre_valid", 32'(resp_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rmid_valid", 32'(resp_valid), 32'd0);
    check("rmid_ready", 32'(req_ready), 32'd1);
    resp_ready = 1'b1;
    drive_req(1'b1, 1, 4);
    step();
    drive_req(1'b0, 0, 0);
    step();
    check("rmid_new_valid", 32'(resp_valid), 32'd1);
    check("rmid_new_tag", 32'(resp_tag), 32'd4);
    check("rmid_new_data", 32'(resp_data), 32'(exp_data(1)));
    step();
    check("rmid_empty", 32'(resp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
